uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. Captures each byte presented with a single-cycle `rx_done` strobe into a synchronous first-word-fall-through FIFO. Offers the bytes to the host/bus side through a valid/ready read port. Flags bytes lost to a full buffer with a sticky overrun bit, and optionally raises a fill-level watermark interrupt.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_fifo_mem.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared defaults and helpers for the UART receive buffer.
//               Holds the default byte width, the default FIFO depth and a
//               clog2 function used to derive the FIFO pointer width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Default byte width. It must match the receiver's rx_data width.
  localparam int c_DATA_W = 8;

  // Default number of FIFO entries. It must be a power of two.
  localparam int c_FIFO_DEPTH = 16;

  // Returns the smallest r such that (1 << r) >= value. The loop has a fixed
  // bound, so the function is usable as a constant function.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x DATA_W register array with one synchronous write port
//               and one asynchronous read port. The storage has no reset.
// Ports       : clk     - clock
//               wr_en   - write enable
//               wr_addr - write address
//               wr_data - write data
//               rd_addr - read address
//               rd_data - read data, combinational from rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = c_FIFO_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : uart_fifo_mem

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive buffer placed downstream of the UART receiver. Each
//               byte strobed in with rx_done goes into a first-word-fall-
//               through FIFO. The bytes are read out through a valid/ready
//               port. A sticky overrun flag records any byte that was dropped
//               because the buffer was full.
//               When the macro UART_RX_FIFO_WM_EN is defined, a registered
//               watermark interrupt is raised while the occupancy is at or
//               above wm_level. When the macro is undefined, wm_irq is 0.
// Ports       : clk         - clock
//               rst         - synchronous active-high reset
//               rx_data     - byte from the receiver, sampled on rx_done
//               rx_done     - one-cycle write strobe
//               rd_data     - head-of-queue byte (valid with rd_valid)
//               rd_valid    - FIFO not empty
//               rd_ready    - consumer accepts rd_data
//               count       - occupancy, 0..DEPTH
//               full        - count == DEPTH
//               overrun     - sticky flag, set when a byte was dropped
//               overrun_clr - clears overrun (a set in the same cycle wins)
//               wm_level    - watermark threshold
//               wm_irq      - watermark interrupt
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = c_FIFO_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              overrun,
  input  logic              overrun_clr,
  input  logic [AW:0]       wm_level,
  output logic              wm_irq
);

  localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overrun;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [AW:0]   w_count_next;

  // Full and empty come from the occupancy counter. The pointers compare
  // equal in both cases, so they cannot tell full from empty.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_pop   = !w_empty && rd_ready;

  // A pop in the same cycle frees the slot, so a full buffer can still
  // accept a write.
  assign w_wr    = rx_done && (!w_full || w_pop);
  assign w_drop  = rx_done && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop) begin
      w_count_next = r_count + c_CNT_ONE;
    end else if (w_pop && !w_wr) begin
      w_count_next = r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      // The pointers wrap naturally because DEPTH is a power of two.
      if (w_wr) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      r_count <= w_count_next;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr),
    .wr_addr (r_wptr),
    .wr_data (rx_data),
    .rd_addr (r_rptr),
    .rd_data (rd_data)
  );

  assign rd_valid = !w_empty;
  assign count    = r_count;
  assign full     = w_full;
  assign overrun  = r_overrun;

`ifdef UART_RX_FIFO_WM_EN
  logic r_wm_irq;

  // The comparison uses the next count, so the interrupt lines up with the
  // occupancy that becomes visible after the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wm_irq <= 1'b0;
    end else begin
      r_wm_irq <= (w_count_next >= wm_level) && (wm_level != '0);
    end
  end

  assign wm_irq = r_wm_irq;
`else
  // The watermark feature is disabled, so the threshold input is not used.
  logic w_wm_level_unused;
  assign w_wm_level_unused = ^wm_level;
  assign wm_irq            = 1'b0;
`endif

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A queue-based model
//               predicts count, rd_valid, full, overrun, rd_data and wm_irq.
//               These predictions are compared against the DUT on every
//               falling edge. Directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

`ifdef UART_RX_FIFO_WM_EN
  localparam logic WM_ON = 1'b1;
`else
  localparam logic WM_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [AW:0]       count;
  logic              full;
  logic              overrun;
  logic              overrun_clr;
  logic [AW:0]       wm_level;
  logic              wm_irq;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .full        (full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .wm_level    (wm_level),
    .wm_irq      (wm_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_q[$];
  bit                m_ovr  = 1'b0;
  bit                m_wm   = 1'b0;
  bit                m_live = 1'b0;

  always @(posedge clk) begin
    bit drop;
    drop = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ovr  = 1'b0;
      m_wm   = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (m_q.size() != 0 && rd_ready) void'(m_q.pop_front());
      if (rx_done) begin
        if (m_q.size() < DEPTH) m_q.push_back(rx_data);
        else drop = 1'b1;
      end
      if (drop) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      m_wm = WM_ON && (m_q.size() >= int'(wm_level)) && (wm_level != 0);
    end
  end

  // Bytes that the DUT handed out, captured as they are accepted.
  logic [DATA_W-1:0] got[$];

  always @(negedge clk) begin
    if (m_live) begin
      check("count",    int'(count),    m_q.size());
      check("rd_valid", int'(rd_valid), int'(m_q.size() != 0));
      check("full",     int'(full),     int'(m_q.size() == DEPTH));
      check("overrun",  int'(overrun),  int'(m_ovr));
      check("wm_irq",   int'(wm_irq),   int'(m_wm));
      if (m_q.size() != 0) check("rd_data", int'(rd_data), int'(m_q[0]));
      if (rd_valid && rd_ready) got.push_back(rd_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] exp3 [3];
    exp3[0] = 8'h55;
    exp3[1] = 8'hA3;
    exp3[2] = 8'h0F;

    rst = 1'b1; rx_data = '0; rx_done = 1'b0; rd_ready = 1'b0;
    overrun_clr = 1'b0; wm_level = 5'd4;
    repeat (2) tick();
    check("reset_count",    int'(count),    0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_overrun",  int'(overrun),  0);
    check("reset_wm_irq",   int'(wm_irq),   0);
    rst = 1'b0;
    tick();

    // Three bytes, then an in-order drain.
    strobe(8'h55); strobe(8'hA3); strobe(8'h0F);
    check("t1_count", int'(count),   3);
    check("t1_head",  int'(rd_data), 8'h55);
    got.delete();
    drain(3);
    check("t1_empty", int'(rd_valid), 0);
    check("t1_ndrained", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("t1_order", int'(got[i]), int'(exp3[i]));

    // Fill the buffer, then strobe while full to cause an overrun.
    for (int i = 0; i < DEPTH; i++) strobe(DATA_W'(i));
    check("t2_full", int'(full), 1);
    check("t2_ovr_before", int'(overrun), 0);
    strobe(8'hEE);
    check("t2_ovr_set", int'(overrun), 1);
    check("t2_count", int'(count), 16);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("t2_ovr_clr", int'(overrun), 0);
    got.delete();
    drain(DEPTH);
    check("t2_ndrained", got.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got.size(); i++) check("t2_order", int'(got[i]), i);

    // A write while full, in the same cycle as a pop.
    for (int i = 0; i < DEPTH; i++) strobe(DATA_W'(8'h20 + i));
    rd_ready = 1'b1; rx_data = 8'h77; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rd_ready = 1'b0;
    check("t3_count", int'(count), 16);
    check("t3_no_ovr", int'(overrun), 0);
    got.delete();
    drain(DEPTH);
    check("t3_ndrained", got.size(), DEPTH);
    if (got.size() == DEPTH) check("t3_last", int'(got[DEPTH-1]), 8'h77);
    if (got.size() == DEPTH) check("t3_first", int'(got[0]), 8'h21);

    // Streaming: one write and one pop per cycle, so the pointers wrap.
    got.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = DATA_W'(8'h80 + i); rx_done = 1'b1;
      tick();
      check("t4_count_le1", int'(count <= 1), 1);
    end
    rx_done = 1'b0;
    tick();
    rd_ready = 1'b0;
    check("t4_ndrained", got.size(), 40);
    for (int i = 0; i < 40 && i < got.size(); i++) check("t4_order", int'(got[i]), 8'h80 + i);

    // Reset in the middle of the stream, with 5 bytes queued and overrun set.
    for (int i = 0; i < DEPTH; i++) strobe(DATA_W'(i));
    strobe(8'hEE);
    drain(11);
    check("t5_count", int'(count), 5);
    check("t5_ovr", int'(overrun), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_count", int'(count), 0);
    check("t5_rst_valid", int'(rd_valid), 0);
    check("t5_rst_ovr", int'(overrun), 0);
    tick();

    // Watermark at level 4.
    wm_level = 5'd4;
    strobe(8'h01); strobe(8'h02); strobe(8'h03);
    check("t6_wm_below", int'(wm_irq), 0);
    strobe(8'h04);
    check("t6_wm_at", int'(wm_irq), int'(WM_ON));
    drain(1);
    check("t6_wm_pop", int'(wm_irq), 0);
    drain(3);
    check("t6_empty", int'(rd_valid), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo

`default_nettype wire
